block_map_wr_arbiter: RTL
=========================

BLOCK_MAP_WR_ARBITER -- requirements
Module: block_map_wr_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all logic on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset, sampled on clk rising edge.
REQ-003 SHALL have ports: init_start  in  1  one-cycle pulse, start level-init sweep of block map.
REQ-004 SHALL have ports: req  in  3  per-requester write request, level, held until granted.
REQ-005 SHALL have ports: addr0, addr1, addr2  in  10 each  block map write address per requester (x + y*33).
REQ-006 SHALL have ports: data0, data1, data2  in  1 each  block map write data per requester (0 = clear block).
REQ-007 SHALL have ports: gnt  out  3  one-hot grant, one-cycle pulse per accepted request.
REQ-008 SHALL have ports: block_w_addr  out  10  block map RAM write address.
REQ-009 SHALL have ports: block_w_data  out  1  block map RAM write data.
REQ-010 SHALL have ports: block_we  out  1  block map RAM write enable.
REQ-011 SHALL have ports: init_busy  out  1  high while the init sweep runs.

Function
REQ-012 SHALL be a 2-state FSM: ARB (arbitrate requesters) and INIT (sweep map).
REQ-013 SHALL register all outputs, with no combinational path from inputs to outputs.
REQ-014 SHALL, in ARB at cycle N, select one eligible requester; at cycle N+1 it asserts gnt[i]=1 and block_we=1, with block_w_addr=addrI and block_w_data=dataI as sampled at N.
REQ-015 SHALL treat a requester as eligible when req[i]=1 and gnt[i]=0 in the current cycle, so a held req is not granted twice.
REQ-016 SHALL use round-robin priority: after granting i, priority order becomes i+1, i+2, i (mod 3); after reset the order is 0, 1, 2.
REQ-017 SHALL drive block_we=0 and gnt=0 on cycles with no eligible requester, and SHALL leave the pointer unchanged on those cycles.
REQ-018 SHALL accept at most one write per cycle, so sustained throughput is one write per cycle when at least two requesters are active.
REQ-019 SHALL, when init_start=1 in ARB, enter INIT on the next edge; no grant is issued for that arbitration cycle, and pending requests stay pending.
REQ-020 SHALL, in INIT, use a 10-bit counter running 0..890 (33x27 map), issuing one write per cycle with block_we=1 and block_w_addr=counter.
REQ-021 SHALL, in INIT, set block_w_data=0 for addresses 0, 1 and 33 (spawn corner) and 1 for every other address.
REQ-022 SHALL hold init_busy=1 from the first INIT write through the write of address 890.
REQ-023 SHALL, after the write of 890, return to ARB, clear the counter, drop init_busy and block_we next cycle, and resume arbitration at the saved pointer.
REQ-024 SHALL ignore init_start while in INIT (no restart).
REQ-025 SHALL hold gnt=0 throughout INIT, and SHALL never write addresses above 890.
REQ-026 SHALL ignore any req bit that drops before its grant, with no grant issued for it.

Reset
REQ-027 SHALL, on reset, set the FSM to ARB, the counter to 0, the round-robin pointer to requester 0, gnt=0, block_we=0, block_w_addr=0, block_w_data=0 and init_busy=0.
REQ-028 SHALL, on reset during INIT, abort the sweep with no further writes; the next cycle follows REQ-027.

Verification
REQ-029 SHALL cover: after reset, req=3'b001, addr0=10'd70, data0=0, held -> next cycle gnt=001, block_we=1, addr=70, data=0; the following cycle gnt=0, block_we=0 (no double grant).
REQ-030 SHALL cover: req=3'b111 held continuously and each requester dropping its req one cycle after its gnt -> grants 001, 010, 100 on consecutive cycles.
REQ-031 SHALL cover: init_start pulse with req=3'b010 pending -> 891 consecutive writes, addresses 0..890; data 0 at 0, 1 and 33, data 1 elsewhere; gnt=0 throughout; gnt=010 on the first ARB grant cycle after init_busy falls.
REQ-032 SHALL cover: second init_start at sweep address 400 -> the sweep continues unbroken to 890, with exactly 891 writes total.
REQ-033 SHALL cover: reset asserted at sweep address 500 -> next cycle block_we=0, init_busy=0; a following req=3'b100 grants 100.
REQ-034 SHALL cover: req[1] pulsed high for one cycle while gnt=001 is being issued -> req[1] is granted only if still high when sampled; a dropped request produces no gnt.

Source files
------------

// File: rtl/block_map_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : block_map_wr_arbiter
// Purpose  : Shares the single write port of the block map RAM between three
//            requesters using round-robin arbitration, and on request performs
//            a level-init sweep of the whole 33x27 map (spawn corner cleared,
//            everything else set).
// Ports    : clk, reset            - clock, synchronous active-high reset
//            init_start            - one-cycle pulse, starts the init sweep
//            req[2:0]              - per-requester write request (level)
//            addr0..2, data0..2    - per-requester write address / data
//            gnt[2:0]              - one-hot grant pulse (registered)
//            block_w_addr/_data/_we- block map RAM write port (registered)
//            init_busy             - high while sweep writes are issued
// Revision : 1.0  initial release
// ============================================================================
module block_map_wr_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic       init_start,
    input  logic [2:0] req,
    input  logic [9:0] addr0,
    input  logic [9:0] addr1,
    input  logic [9:0] addr2,
    input  logic       data0,
    input  logic       data1,
    input  logic       data2,
    output logic [2:0] gnt,
    output logic [9:0] block_w_addr,
    output logic       block_w_data,
    output logic       block_we,
    output logic       init_busy
);

    localparam logic [0:0] c_ST_ARB    = 1'b0;
    localparam logic [0:0] c_ST_INIT   = 1'b1;
    localparam logic [9:0] c_LAST_ADDR = 10'd890;  // 33*27 - 1
    localparam logic [9:0] c_MAP_W     = 10'd33;

    logic [0:0] r_state;
    logic [9:0] r_cnt;
    logic [1:0] r_ptr;

    logic [2:0] w_elig;
    logic [1:0] w_cand0;
    logic [1:0] w_cand1;
    logic [1:0] w_cand2;
    logic       w_found;
    logic [1:0] w_sel;
    logic [1:0] w_next_ptr;
    logic [2:0] w_sel_oh;
    logic [9:0] w_sel_addr;
    logic       w_sel_data;
    logic       w_init_data;

    // A requester granted last cycle is masked so a held req is not granted
    // twice. While init_busy is still high the last sweep write is on the
    // port, so arbitration waits one more cycle before resuming.
    assign w_elig = req & ~gnt & {3{~init_busy}};

    // Priority order: r_ptr, r_ptr+1, r_ptr+2 (mod 3)
    assign w_cand0 = r_ptr;
    assign w_cand1 = (r_ptr == 2'd2) ? 2'd0 : r_ptr + 2'd1;
    assign w_cand2 = (r_ptr == 2'd0) ? 2'd2 : r_ptr - 2'd1;

    always_comb begin
        w_found = 1'b1;
        w_sel   = w_cand0;
        if (w_elig[w_cand0]) begin
            w_sel = w_cand0;
        end else if (w_elig[w_cand1]) begin
            w_sel = w_cand1;
        end else if (w_elig[w_cand2]) begin
            w_sel = w_cand2;
        end else begin
            w_found = 1'b0;
            w_sel   = w_cand0;
        end
    end

    assign w_sel_oh   = 3'b001 << w_sel;
    assign w_next_ptr = (w_sel == 2'd2) ? 2'd0 : w_sel + 2'd1;

    always_comb begin
        w_sel_addr = addr0;
        w_sel_data = data0;
        case (w_sel)
            2'd1: begin
                w_sel_addr = addr1;
                w_sel_data = data1;
            end
            2'd2: begin
                w_sel_addr = addr2;
                w_sel_data = data2;
            end
            default: begin
                w_sel_addr = addr0;
                w_sel_data = data0;
            end
        endcase
    end

    // Spawn corner (0,0), (1,0), (0,1) is left open; every other block is set
    assign w_init_data = ~((r_cnt == 10'd0) | (r_cnt == 10'd1) | (r_cnt == c_MAP_W));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_ST_ARB;
            r_cnt        <= 10'd0;
            r_ptr        <= 2'd0;
            gnt          <= 3'b000;
            block_we     <= 1'b0;
            block_w_addr <= 10'd0;
            block_w_data <= 1'b0;
            init_busy    <= 1'b0;
        end else begin
            case (r_state)
                c_ST_ARB: begin
                    gnt       <= 3'b000;
                    block_we  <= 1'b0;
                    init_busy <= 1'b0;
                    if (init_start) begin
                        // Sweep takes precedence; pending requests wait it out
                        r_state <= c_ST_INIT;
                        r_cnt   <= 10'd0;
                    end else if (w_found) begin
                        gnt          <= w_sel_oh;
                        block_we     <= 1'b1;
                        block_w_addr <= w_sel_addr;
                        block_w_data <= w_sel_data;
                        r_ptr        <= w_next_ptr;
                    end
                end
                default: begin
                    // init_start is deliberately not looked at here
                    gnt          <= 3'b000;
                    block_we     <= 1'b1;
                    init_busy    <= 1'b1;
                    block_w_addr <= r_cnt;
                    block_w_data <= w_init_data;
                    if (r_cnt == c_LAST_ADDR) begin
                        r_state <= c_ST_ARB;
                        r_cnt   <= 10'd0;
                    end else begin
                        r_cnt <= r_cnt + 10'd1;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire
